wb_bridge_arbiter: RTL and testbench

Round-robin arbiter that shares one wishbone slave port, the wishbone-to-FTA bridge, between NMASTER wishbone masters. Grant is held for the master's whole cyc_i (bus lock), so a master's src/dst/blen register writes and its burst trigger are never interleaved with another master's. A watchdog aborts hung transfers with an error. The block sits between the CPU/DMA-side masters and the bridge's wishbone port.

---
 rtl/fta_bus_pkg.sv | 9 +
 rtl/wb_arb_pkg.sv | 17 +
 rtl/wb_bridge_arbiter_rr_pick.sv | 26 ++
 rtl/wb_bridge_arbiter.sv | 126 ++++++++++++
 tb/tb_wb_bridge_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fta_bus_pkg.sv
// Response codes shared by the FTA bus and the wishbone bridge ports.
package fta_bus_pkg;

    typedef logic [2:0] fta_err_t;

    localparam fta_err_t OKAY = 3'd0;
    localparam fta_err_t ERR  = 3'd2;

endpackage

// File: rtl/wb_arb_pkg.sv
// Shared types for the wishbone bridge arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_ABORT,
        ARB_RELEASE
    } arb_state_e;

    localparam int WDOG_W = 10;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/wb_bridge_arbiter_rr_pick.sv
// Round-robin pick: first requester at or after base, searching upward with wrap.
module rr_pick #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] base,
    output logic [W-1:0] idx,
    output logic         any
);

    int j;

    // Scan from farthest to nearest so the nearest requester is written last.
    always_comb begin
        idx = '0;
        j   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(base) + k;
            if (j >= N) j = j - N;
            if (req[j]) idx = W'(j);
        end
        any = |req;
    end

endmodule

// File: rtl/wb_bridge_arbiter.sv
// Round-robin, cycle-locked arbiter sharing the wishbone-to-FTA bridge port
// between NMASTER masters, with a watchdog that aborts hung transfers.
module wb_bridge_arbiter
    import wb_arb_pkg::*;
    import fta_bus_pkg::*;
#(
    parameter int NMASTER = 4,
    parameter int WID     = 256,
    parameter int TIMEOUT = 1023,
    localparam int GW     = $clog2(NMASTER)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NMASTER-1:0]                m_cyc_i,
    input  logic [NMASTER-1:0]                m_stb_i,
    input  logic [NMASTER-1:0]                m_we_i,
    input  logic [NMASTER-1:0][WID/8-1:0]     m_sel_i,
    input  logic [NMASTER-1:0][31:0]          m_adr_i,
    input  logic [NMASTER-1:0][WID-1:0]       m_dat_i,
    output logic [NMASTER-1:0]                m_ack_o,
    output logic [NMASTER-1:0][2:0]           m_err_o,
    output logic [WID-1:0]                    m_dat_o,
    output logic                              s_cs_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [WID/8-1:0]                  s_sel_o,
    output logic [31:0]                       s_adr_o,
    output logic [WID-1:0]                    s_dat_o,
    input  logic                              s_ack_i,
    input  logic [2:0]                        s_err_i,
    input  logic [WID-1:0]                    s_dat_i,
    output logic [GW-1:0]                     grant_o,
    output logic                              busy_o
);

    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    arb_state_e          state;
    logic [GW-1:0]       g;
    logic [GW-1:0]       ptr;
    logic [GW-1:0]       pick_idx;
    logic                pick_any;
    logic [WDOG_W-1:0]   wdog;
    logic [NMASTER-1:0]  req;
    logic                in_busy;
    logic                in_abort;

    assign req      = m_cyc_i & m_stb_i;
    assign in_busy  = (state == ARB_BUSY);
    assign in_abort = (state == ARB_ABORT);

    rr_pick #(.N(NMASTER)) u_pick (
        .req  (req),
        .base (ptr),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ARB_IDLE;
            g     <= '0;
            ptr   <= '0;
            wdog  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        g     <= pick_idx;
                        wdog  <= '0;
                        state <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    // Master drop beats a same-cycle timeout; ack beats it too.
                    if (!m_cyc_i[g]) begin
                        state <= ARB_RELEASE;
                    end else if (s_ack_i) begin
                        wdog <= '0;
                    end else if (req[g]) begin
                        wdog <= wdog + 1'b1;
                        if (wdog == WDOG_LAST) state <= ARB_ABORT;
                    end
                end
                ARB_ABORT: begin
                    if (!m_cyc_i[g]) state <= ARB_RELEASE;
                end
                ARB_RELEASE: begin
                    // Bridge may hold ack until the request is gone; wait it out.
                    if (!s_ack_i) begin
                        ptr   <= GW'(wrap_inc(int'(g), NMASTER));
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Outputs decode the state register, so reset clears them without a clock.
    always_comb begin
        s_cyc_o = in_busy & m_cyc_i[g];
        s_cs_o  = s_cyc_o;
        s_stb_o = s_cyc_o & m_stb_i[g];
        s_we_o  = in_busy & m_we_i[g];
        s_sel_o = in_busy ? m_sel_i[g] : '0;
        s_adr_o = in_busy ? m_adr_i[g] : '0;
        s_dat_o = in_busy ? m_dat_i[g] : '0;

        m_ack_o = '0;
        m_err_o = {NMASTER{OKAY}};
        if (in_busy) begin
            m_ack_o[g] = s_ack_i;
            m_err_o[g] = s_err_i;
        end else if (in_abort) begin
            m_ack_o[g] = 1'b1;
            m_err_o[g] = ERR;
        end
    end

    assign m_dat_o = s_dat_i;
    assign grant_o = g;
    assign busy_o  = (state != ARB_IDLE);

endmodule

// File: tb/tb_wb_bridge_arbiter.sv
// Directed + randomized bench for wb_bridge_arbiter against a rotation model.
module tb_wb_bridge_arbiter;
    import fta_bus_pkg::*;

    localparam int NM  = 4;
    localparam int WD  = 32;
    localparam int TO  = 20;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NM-1:0]         m_cyc, m_stb, m_we;
    logic [NM-1:0][WD/8-1:0] m_sel;
    logic [NM-1:0][31:0]   m_adr;
    logic [NM-1:0][WD-1:0] m_dat;
    logic [NM-1:0]         m_ack_o;
    logic [NM-1:0][2:0]    m_err_o;
    logic [WD-1:0]         m_dat_o;
    logic                  s_cs_o, s_cyc_o, s_stb_o, s_we_o;
    logic [WD/8-1:0]       s_sel_o;
    logic [31:0]           s_adr_o;
    logic [WD-1:0]         s_dat_o;
    logic                  s_ack;
    logic [2:0]            s_err;
    logic [WD-1:0]         s_dat;
    logic [1:0]            grant_o;
    logic                  busy_o;

    int total = 0;
    int bad   = 0;
    int mptr  = 0;

    wb_bridge_arbiter #(.NMASTER(NM), .WID(WD), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
        .m_adr_i(m_adr), .m_dat_i(m_dat),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
        .s_cs_o(s_cs_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_dat_i(s_dat),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rotation: nearest requester at or after base, modulo NM.
    function automatic int pick(input logic [NM-1:0] r, input int base);
        for (int k = 0; k < NM; k++)
            if (r[(base + k) % NM]) return (base + k) % NM;
        return -1;
    endfunction

    function automatic logic [63:0] onehot(input int m);
        logic [63:0] v;
        v = '0;
        v[m] = 1'b1;
        return v;
    endfunction

    task automatic raise(input int m);
        m_cyc[m] = 1'b1;
        m_stb[m] = 1'b1;
        m_we[m]  = 1'($urandom_range(0, 1));
        m_sel[m] = 4'($urandom);
        m_adr[m] = $urandom;
        m_dat[m] = $urandom;
    endtask

    task automatic clear_all();
        m_cyc = '0;
        m_stb = '0;
    endtask

    // One full grant starting in IDLE with requests already asserted.
    task automatic serve(input int delay, input bit rearm);
        int g;
        logic [31:0] rd;
        g = pick(m_cyc & m_stb, mptr);
        chk("idle_quiet", 64'(s_cyc_o), 64'd0);
        tick();
        chk("grant", 64'(grant_o), 64'(g));
        chk("s_cyc", 64'(s_cyc_o), 64'd1);
        chk("s_adr", 64'(s_adr_o), 64'(m_adr[g]));
        chk("s_we", 64'(s_we_o), 64'(m_we[g]));
        chk("s_sel", 64'(s_sel_o), 64'(m_sel[g]));
        chk("s_dat", 64'(s_dat_o), 64'(m_dat[g]));
        for (int d = 0; d < delay; d++) begin
            chk("ack_wait", 64'(m_ack_o), 64'd0);
            tick();
        end
        rd = $urandom;
        s_ack = 1'b1;
        s_dat = rd;
        #1;
        chk("ack_own", 64'(m_ack_o), onehot(g));
        chk("rdata", 64'(m_dat_o), 64'(rd));
        chk("err_ok", 64'(m_err_o), 64'({NM{OKAY}}));
        tick();
        s_ack = 1'b0;
        m_cyc[g] = 1'b0;
        m_stb[g] = 1'b0;
        #1;
        chk("drop_cyc", 64'(s_cyc_o), 64'd0);
        tick();
        chk("rel_busy", 64'(busy_o), 64'd1);
        chk("rel_quiet", 64'(s_cyc_o), 64'd0);
        mptr = (g + 1) % NM;
        if (rearm) raise(g);
        tick();
        chk("idle_busy", 64'(busy_o), 64'd0);
    endtask

    initial begin
        int g;
        logic [31:0] rd;
        logic [11:0] eerr;

        rst = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
        s_ack = 1'b0; s_err = OKAY; s_dat = '0;
        #1;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_grant", 64'(grant_o), 64'd0);
        chk("rst_scyc", 64'(s_cyc_o), 64'd0);
        chk("rst_ack", 64'(m_ack_o), 64'd0);
        chk("rst_err", 64'(m_err_o), 64'({NM{OKAY}}));
        tick(); tick();
        rst = 1'b0;
        tick();

        // Masters 0,2,3 together from ptr 0; master 0 re-requests after its turn.
        raise(0); raise(2); raise(3);
        serve(1, 1);
        serve(0, 0);
        serve(2, 0);
        serve(0, 0);

        // Single master 1 write, bridge acks on the second BUSY cycle.
        raise(1);
        m_we[1] = 1'b1; m_adr[1] = 32'h7FFF_FFF0; m_dat[1] = 32'h1000;
        #1;
        chk("t1_idle_scyc", 64'(s_cyc_o), 64'd0);
        serve(1, 0);

        // All masters requesting continuously: strict rotation.
        for (int m = 0; m < NM; m++) raise(m);
        for (int n = 0; n < 2 * NM; n++) serve($urandom_range(0, 2), 1);
        clear_all();
        tick(); tick(); tick();
        mptr = mptr;

        // Master 0 holds cyc across four beats while master 1 waits.
        raise(0);
        g = pick(m_cyc & m_stb, mptr);
        tick();
        chk("lock_grant", 64'(grant_o), 64'(g));
        raise(1);
        for (int b = 0; b < 4; b++) begin
            m_adr[0] = 32'hF0 + 32'(4 * b);
            m_we[0]  = (b < 3);
            m_stb[0] = 1'b1;
            rd = $urandom;
            s_ack = 1'b1;
            s_dat = rd;
            #1;
            chk("lock_adr", 64'(s_adr_o), 64'(32'hF0 + 32'(4 * b)));
            chk("lock_ack", 64'(m_ack_o), 64'd1);
            if (b == 3) chk("lock_rdata", 64'(m_dat_o), 64'(rd));
            tick();
            m_stb[0] = 1'b0;
            s_ack = 1'b0;
            #1;
            chk("lock_hold_cyc", 64'(s_cyc_o), 64'd1);
            chk("lock_hold_grant", 64'(grant_o), 64'd0);
            chk("lock_no_ack", 64'(m_ack_o), 64'd0);
            tick();
        end
        m_cyc[0] = 1'b0;
        tick();
        chk("lock_rel_grant", 64'(grant_o), 64'd0);
        mptr = 1;
        tick();
        chk("lock_idle", 64'(busy_o), 64'd0);
        serve(0, 0);

        // Bridge never acks: watchdog aborts with ERR held until cyc drops.
        raise(2);
        g = pick(m_cyc & m_stb, mptr);
        tick();
        for (int c = 1; c <= TO; c++) begin
            chk("wd_active", 64'(s_cyc_o), 64'd1);
            tick();
        end
        eerr = {NM{OKAY}};
        eerr[g*3 +: 3] = ERR;
        for (int c = 0; c < 3; c++) begin
            chk("wd_scyc_off", 64'(s_cyc_o), 64'd0);
            chk("wd_sstb_off", 64'(s_stb_o), 64'd0);
            chk("wd_ack", 64'(m_ack_o), onehot(g));
            chk("wd_err", 64'(m_err_o), 64'(eerr));
            tick();
        end
        m_cyc[g] = 1'b0; m_stb[g] = 1'b0;
        tick();
        chk("wd_rel_ack", 64'(m_ack_o), 64'd0);
        mptr = (g + 1) % NM;
        tick();
        chk("wd_idle", 64'(busy_o), 64'd0);

        // Drop in the timeout cycle: no error.
        raise(1);
        g = pick(m_cyc & m_stb, mptr);
        tick();
        for (int c = 1; c < TO; c++) tick();
        m_cyc[g] = 1'b0; m_stb[g] = 1'b0;
        tick();
        chk("drop_win_ack", 64'(m_ack_o), 64'd0);
        chk("drop_win_err", 64'(m_err_o), 64'({NM{OKAY}}));
        chk("drop_win_busy", 64'(busy_o), 64'd1);
        mptr = (g + 1) % NM;
        tick();

        // Ack in the timeout cycle: watchdog clears, transfer continues.
        raise(3);
        g = pick(m_cyc & m_stb, mptr);
        tick();
        for (int c = 1; c < TO; c++) tick();
        s_ack = 1'b1;
        #1;
        chk("ack_win_ack", 64'(m_ack_o), onehot(g));
        tick();
        s_ack = 1'b0;
        for (int c = 1; c < TO; c++) begin
            chk("ack_win_cyc", 64'(s_cyc_o), 64'd1);
            tick();
        end
        m_cyc[g] = 1'b0; m_stb[g] = 1'b0;
        tick();
        mptr = (g + 1) % NM;
        tick();
        chk("ack_win_idle", 64'(busy_o), 64'd0);

        // Bridge holds ack after cyc drops; competitor waits for RELEASE to end.
        raise(2);
        g = pick(m_cyc & m_stb, mptr);
        tick();
        raise(0);
        s_ack = 1'b1;
        tick();
        m_cyc[g] = 1'b0; m_stb[g] = 1'b0;
        tick();
        for (int c = 0; c < 3; c++) begin
            chk("hold_busy", 64'(busy_o), 64'd1);
            chk("hold_scyc", 64'(s_cyc_o), 64'd0);
            chk("hold_grant", 64'(grant_o), 64'(g));
            tick();
        end
        chk("hold_still_rel", 64'(busy_o), 64'd1);
        s_ack = 1'b0;
        mptr = (g + 1) % NM;
        tick();
        chk("hold_idle", 64'(busy_o), 64'd0);
        serve(0, 0);

        // Randomized request mixes.
        for (int it = 0; it < 24; it++) begin
            for (int m = 0; m < NM; m++)
                if (!m_cyc[m] && $urandom_range(0, 1) == 1) raise(m);
            if (m_cyc == '0) raise(int'($urandom_range(0, NM - 1)));
            serve(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of BUSY.
        clear_all();
        raise(1);
        tick();
        chk("pre_rst_cyc", 64'(s_cyc_o), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_scyc", 64'(s_cyc_o), 64'd0);
        chk("arst_sstb", 64'(s_stb_o), 64'd0);
        chk("arst_sadr", 64'(s_adr_o), 64'd0);
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_grant", 64'(grant_o), 64'd0);
        chk("arst_ack", 64'(m_ack_o), 64'd0);
        clear_all();
        tick();
        rst = 1'b0;
        mptr = 0;
        tick();
        raise(3);
        serve(0, 0);
        raise(1); raise(2);
        serve(1, 0);
        serve(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout total=%0d", total);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
